// File: rtl/home_pkg.sv
// Shared definitions for the sensor front end and the home automation controller.
package home_pkg;

  // Scan sequencer states.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_FRAME_T = 2'd1,
    ST_FRAME_L = 2'd2,
    ST_UPDATE  = 2'd3
  } scan_state_t;

  // ADC channel codes, sent as the first MOSI bit of a frame.
  localparam logic CH_TEMP = 1'b0;
  localparam logic CH_LUM  = 1'b1;

  // Alarm thresholds used by the controller.
  localparam logic [7:0] TEMP_THR = 8'd70;
  localparam logic [7:0] LUM_THR  = 8'd15;

  // A frame is split into 34 phases of CLK_DIV clk cycles each:
  //   phase 0        setup, cs_n low, sclk low
  //   phases 1..32   SCLK halves; odd = high half of period (ph-1)/2
  //   phase 33       cs_n high tail before the next frame
  localparam logic [5:0] PH_LAST_CLK   = 6'd31;
  localparam logic [5:0] PH_DATA_FIRST = 6'd17;
  localparam logic [5:0] PH_TAIL       = 6'd33;

endpackage

// File: rtl/sensor_debounce.sv
// Two-flop synchroniser plus stability counter for one raw contact.
module sensor_debounce #(
  parameter int DEB_CNT = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic clean
);

  localparam int CW = (DEB_CNT > 1) ? $clog2(DEB_CNT) : 1;

  logic          sync1_q;
  logic          sync2_q;
  logic          clean_q;
  logic [CW-1:0] cnt_q;

  // Bring the asynchronous contact into the clk domain.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
    end
  end

  // Follow the synchronised value only after DEB_CNT consecutive differing cycles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q   <= '0;
      clean_q <= 1'b0;
    end else if (sync2_q != clean_q) begin
      if (cnt_q == CW'(DEB_CNT - 1)) begin
        clean_q <= sync2_q;
        cnt_q   <= '0;
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end else begin
      cnt_q <= '0;
    end
  end

  assign clean = clean_q;

endmodule

// File: rtl/sensor_frontend.sv
// Scans the 2-channel serial ADC and debounces the door and fire contacts.
//
//   state      | meaning
//   -----------+------------------------------------------------------
//   ST_IDLE    | gap counter runs; waits for scan_en after SCAN_GAP cycles
//   ST_FRAME_T | ADC frame on ch0 (temperature), result kept in tbuf_q
//   ST_FRAME_L | ADC frame on ch1 (luminance), result left in shift_q
//   ST_UPDATE  | one cycle: both samples published, sample_vld high
module sensor_frontend
  import home_pkg::*;
#(
  parameter int CLK_DIV  = 4,
  parameter int SCAN_GAP = 16,
  parameter int DEB_CNT  = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scan_en,
  input  logic       adc_miso,
  input  logic       door_raw,
  input  logic       fire_raw,
  output logic       adc_cs_n,
  output logic       adc_sclk,
  output logic       adc_mosi,
  output logic [7:0] temp_sen,
  output logic [7:0] lum_sen,
  output logic       d_sen,
  output logic       f_sen,
  output logic       sample_vld
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int GW = $clog2(SCAN_GAP + 1);

  scan_state_t   state_q, state_d;
  logic [DW-1:0] div_q, div_d;
  logic [5:0]    ph_q, ph_d;
  logic [GW-1:0] gap_q, gap_d;
  logic          frame_last;
  logic          frame_d;
  logic          cs_n_d, sclk_d, mosi_d, sample_d;
  logic          cs_n_q, sclk_q, mosi_q, vld_q;
  logic [7:0]    shift_q, tbuf_q, temp_q, lum_q;

  assign frame_last = (div_q == DW'(CLK_DIV - 1)) && (ph_q == PH_TAIL);

  // Next state, divider, phase and gap counters.
  always_comb begin
    state_d = state_q;
    div_d   = '0;
    ph_d    = '0;
    gap_d   = '0;
    case (state_q)
      ST_IDLE: begin
        gap_d = (gap_q == GW'(SCAN_GAP)) ? gap_q : gap_q + GW'(1);
        if (scan_en && (gap_q >= GW'(SCAN_GAP - 1))) begin
          state_d = ST_FRAME_T;
          gap_d   = '0;
        end
      end
      ST_FRAME_T, ST_FRAME_L: begin
        if (div_q == DW'(CLK_DIV - 1)) begin
          div_d = '0;
          ph_d  = ph_q + 6'd1;
        end else begin
          div_d = div_q + DW'(1);
          ph_d  = ph_q;
        end
        if (frame_last) begin
          ph_d    = '0;
          state_d = (state_q == ST_FRAME_T) ? ST_FRAME_L : ST_UPDATE;
        end
      end
      ST_UPDATE: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // ADC pin values decoded from the next frame position so the pins come straight from flops.
  // MOSI drops one cycle into the low half of period 0 so it never moves with an SCLK edge.
  always_comb begin
    frame_d  = (state_d == ST_FRAME_T) || (state_d == ST_FRAME_L);
    cs_n_d   = !(frame_d && (ph_d != PH_TAIL));
    sclk_d   = frame_d && ph_d[0] && (ph_d <= PH_LAST_CLK);
    mosi_d   = frame_d && ((state_d == ST_FRAME_L) ? CH_LUM : CH_TEMP) &&
               ((ph_d < 6'd2) || ((ph_d == 6'd2) && (div_d == '0)));
    sample_d = sclk_d && (div_d == '0) && (ph_d >= PH_DATA_FIRST);
  end

  // Sequencer registers, shift register, buffers and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      div_q   <= '0;
      ph_q    <= '0;
      gap_q   <= '0;
      cs_n_q  <= 1'b1;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
      vld_q   <= 1'b0;
      shift_q <= '0;
      tbuf_q  <= '0;
      temp_q  <= '0;
      lum_q   <= '0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      ph_q    <= ph_d;
      gap_q   <= gap_d;
      cs_n_q  <= cs_n_d;
      sclk_q  <= sclk_d;
      mosi_q  <= mosi_d;
      vld_q   <= (state_d == ST_UPDATE);
      if (sample_d) begin
        shift_q <= {shift_q[6:0], adc_miso};
      end
      if ((state_q == ST_FRAME_T) && (state_d == ST_FRAME_L)) begin
        tbuf_q <= shift_q;
      end
      if (state_d == ST_UPDATE) begin
        temp_q <= tbuf_q;
        lum_q  <= shift_q;
      end
    end
  end

  sensor_debounce #(.DEB_CNT(DEB_CNT)) u_door_deb (
    .clk   (clk),
    .reset (reset),
    .raw   (door_raw),
    .clean (d_sen)
  );

  sensor_debounce #(.DEB_CNT(DEB_CNT)) u_fire_deb (
    .clk   (clk),
    .reset (reset),
    .raw   (fire_raw),
    .clean (f_sen)
  );

  assign adc_cs_n   = cs_n_q;
  assign adc_sclk   = sclk_q;
  assign adc_mosi   = mosi_q;
  assign temp_sen   = temp_q;
  assign lum_sen    = lum_q;
  assign sample_vld = vld_q;

endmodule

// File: tb/tb_sensor_frontend.sv
// Bench for sensor_frontend: behavioural ADC, protocol scoreboard and debounce window model.
module tb_sensor_frontend;

  localparam int CD = 4;
  localparam int SG = 16;
  localparam int DC = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       scan_en = 1'b0;
  logic       adc_miso = 1'b0;
  logic       door_raw = 1'b0;
  logic       fire_raw = 1'b0;
  logic       adc_cs_n, adc_sclk, adc_mosi;
  logic [7:0] temp_sen, lum_sen;
  logic       d_sen, f_sen, sample_vld;

  int checks = 0;
  int errors = 0;

  // ADC model contents per channel
  logic [7:0] tdata = 8'hA5;
  logic [7:0] ldata = 8'h0C;

  sensor_frontend #(.CLK_DIV(CD), .SCAN_GAP(SG), .DEB_CNT(DC)) dut (
    .clk        (clk),
    .reset      (reset),
    .scan_en    (scan_en),
    .adc_miso   (adc_miso),
    .door_raw   (door_raw),
    .fire_raw   (fire_raw),
    .adc_cs_n   (adc_cs_n),
    .adc_sclk   (adc_sclk),
    .adc_mosi   (adc_mosi),
    .temp_sen   (temp_sen),
    .lum_sen    (lum_sen),
    .d_sen      (d_sen),
    .f_sen      (f_sen),
    .sample_vld (sample_vld)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Debounce model: output takes value v once the last DC synchronised samples all equal v.
  bit hist [2][DC+2];
  bit m_out [2];
  always @(posedge clk) begin
    bit raw_now [2];
    bit stable;
    raw_now[0] = door_raw;
    raw_now[1] = fire_raw;
    for (int c = 0; c < 2; c++) begin
      if (reset) begin
        for (int i = 0; i < DC + 2; i++) hist[c][i] = 1'b0;
        m_out[c] = 1'b0;
      end else begin
        for (int i = DC + 1; i > 0; i--) hist[c][i] = hist[c][i-1];
        hist[c][0] = raw_now[c];
        stable = 1'b1;
        for (int i = 2; i < DC + 2; i++) if (hist[c][i] != hist[c][2]) stable = 1'b0;
        if (stable && (hist[c][2] != m_out[c])) m_out[c] = hist[c][2];
      end
    end
  end

  // ADC model, frame protocol checks and output scoreboard, evaluated mid-cycle.
  int         rcount = 0;
  int         low_cnt = 0;
  int         due = 0;
  logic       cur_ch = 1'b0;
  logic       exp_ch = 1'b0;
  logic [7:0] fbyte = '0;
  logic [7:0] t_byte = '0;
  logic [7:0] l_byte = '0;
  logic [7:0] exp_temp = '0;
  logic [7:0] exp_lum = '0;
  logic       exp_vld;
  logic       prev_cs = 1'b1;
  logic       prev_sclk = 1'b0;
  logic       prev_mosi = 1'b0;

  always @(negedge clk) begin
    if (reset) begin
      chk("rst_cs_n", adc_cs_n, 1'b1);
      chk("rst_sclk", adc_sclk, 1'b0);
      chk("rst_mosi", adc_mosi, 1'b0);
      chk("rst_temp", temp_sen, 8'h00);
      chk("rst_lum", lum_sen, 8'h00);
      chk("rst_vld", sample_vld, 1'b0);
      chk("rst_door", d_sen, 1'b0);
      chk("rst_fire", f_sen, 1'b0);
      rcount = 0; low_cnt = 0; due = 0; exp_ch = 1'b0; fbyte = '0;
      exp_temp = '0; exp_lum = '0;
      prev_cs = 1'b1; prev_sclk = 1'b0; prev_mosi = 1'b0;
      adc_miso = 1'b0;
    end else begin
      exp_vld = 1'b0;
      if (due > 0) begin
        due--;
        if (due == 0) exp_vld = 1'b1;
      end
      if (adc_mosi != prev_mosi) chk("mosi_edge_sclk_low", {prev_sclk, adc_sclk}, 2'b00);
      if (!adc_cs_n) begin
        if (prev_cs) begin
          low_cnt = 0; rcount = 0; fbyte = '0;
        end
        low_cnt++;
        if (adc_sclk && !prev_sclk) begin
          rcount++;
          if (rcount == 1) begin
            chk("mosi_channel", adc_mosi, exp_ch);
            cur_ch = adc_mosi;
          end else begin
            chk("mosi_zero", adc_mosi, 1'b0);
          end
          if (rcount >= 9 && rcount <= 16) fbyte = {fbyte[6:0], adc_miso};
        end
      end else begin
        chk("sclk_idle_low", adc_sclk, 1'b0);
        if (!prev_cs) begin
          chk("cs_low_cycles", low_cnt, 33 * CD);
          chk("sclk_rises", rcount, 16);
          if (cur_ch == 1'b0) begin
            t_byte = fbyte;
            exp_ch = 1'b1;
          end else begin
            l_byte = fbyte;
            exp_ch = 1'b0;
            due = CD;
          end
        end
      end
      if (exp_vld) begin
        exp_temp = t_byte;
        exp_lum  = l_byte;
      end
      chk("sample_vld", sample_vld, exp_vld);
      chk("temp_sen", temp_sen, exp_temp);
      chk("lum_sen", lum_sen, exp_lum);
      chk("d_sen", d_sen, m_out[0]);
      chk("f_sen", f_sen, m_out[1]);
      prev_cs = adc_cs_n;
      prev_sclk = adc_sclk;
      prev_mosi = adc_mosi;
      if (!adc_cs_n && rcount >= 8 && rcount <= 15)
        adc_miso = cur_ch ? ldata[15-rcount] : tdata[15-rcount];
      else
        adc_miso = 1'b0;
    end
  end

  task automatic wait_vld(input int maxc, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!sample_vld && n < maxc);
    if (!sample_vld) begin
      checks++;
      errors++;
      $display("FAIL wait_vld timeout actual=%0d cycles required=pulse", n);
    end
  endtask

  task automatic wait_cs_fall(input int maxc);
    logic prev;
    int   n;
    prev = adc_cs_n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (prev && !adc_cs_n) return;
      prev = adc_cs_n;
    end while (n < maxc);
    checks++;
    errors++;
    $display("FAIL wait_cs_fall timeout actual=%0d cycles required=falling cs_n", n);
  endtask

  initial begin
    int n;
    int pulses;
    int falls;
    int dl;
    int fl;
    logic seen;
    logic pcs;

    // 1: first scan from reset
    scan_en = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    wait_vld(600, n);
    chk("first_vld_latency", n, SG + 68 * CD);
    chk("t1_temp", temp_sen, 8'hA5);
    chk("t1_lum", lum_sen, 8'h0C);
    @(negedge clk);
    chk("vld_single_cycle", sample_vld, 1'b0);

    // 3: data change early in FRAME_L
    wait_cs_fall(200);
    wait_cs_fall(400);
    repeat (10) @(negedge clk);
    tdata = 8'h46;
    ldata = 8'hFF;
    wait_vld(400, n);
    chk("t3_temp_old", temp_sen, 8'hA5);
    chk("t3_lum_new", lum_sen, 8'hFF);
    wait_vld(400, n);
    chk("t3_temp_next", temp_sen, 8'h46);
    chk("t3_lum_next", lum_sen, 8'hFF);

    // 4: door glitch then clean edge
    door_raw = 1'b1;
    repeat (DC - 2) @(negedge clk);
    door_raw = 1'b0;
    repeat (20) @(negedge clk);
    chk("door_glitch_blocked", d_sen, 1'b0);
    door_raw = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!d_sen && n < 50);
    chk("door_latency", n, DC + 2);
    chk("door_set", d_sen, 1'b1);

    // 5: reset in FRAME_T period 10
    wait_vld(400, n);
    wait_cs_fall(100);
    repeat (CD + 2 * CD * 10 + 1) @(negedge clk);
    chk("t5_in_frame", adc_cs_n, 1'b0);
    #2 reset = 1'b1;
    #1;
    chk("t5_cs_n", adc_cs_n, 1'b1);
    chk("t5_sclk", adc_sclk, 1'b0);
    chk("t5_mosi", adc_mosi, 1'b0);
    chk("t5_temp", temp_sen, 8'h00);
    chk("t5_lum", lum_sen, 8'h00);
    chk("t5_vld", sample_vld, 1'b0);
    chk("t5_door", d_sen, 1'b0);
    chk("t5_fire", f_sen, 1'b0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    wait_vld(600, n);
    chk("t5_restart_latency", n, SG + 68 * CD);
    chk("t5_restart_temp", temp_sen, 8'h46);
    chk("t5_restart_lum", lum_sen, 8'hFF);

    // 6: scan_en dropped during FRAME_T
    wait_cs_fall(100);
    repeat (5) @(negedge clk);
    scan_en = 1'b0;
    pulses = 0;
    falls = 0;
    seen = 1'b0;
    pcs = adc_cs_n;
    for (int i = 0; i < 700; i++) begin
      @(negedge clk);
      if (sample_vld) begin
        pulses++;
        seen = 1'b1;
      end else if (seen && pcs && !adc_cs_n) begin
        falls++;
      end
      pcs = adc_cs_n;
    end
    chk("t6_one_pulse", pulses, 1);
    chk("t6_no_new_frame", falls, 0);
    chk("t6_cs_idle", adc_cs_n, 1'b1);

    // random contacts, ADC data and scan_en
    scan_en = 1'b1;
    dl = $urandom_range(1, 20);
    fl = $urandom_range(1, 20);
    pulses = 0;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (dl == 0) begin
        door_raw = ~door_raw;
        dl = $urandom_range(1, 20);
      end else dl--;
      if (fl == 0) begin
        fire_raw = ~fire_raw;
        fl = $urandom_range(1, 20);
      end else fl--;
      if (sample_vld) begin
        pulses++;
        tdata = 8'($urandom);
        ldata = 8'($urandom);
      end
      if ($urandom_range(0, 599) == 0) scan_en = ~scan_en;
    end
    chk("rand_pulses_seen", (pulses > 0), 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
